// File: rtl/instr_fmt_pkg.sv
// instr_fmt_pkg: format codes, opcodes and NOP for the instruction packer.
// Define PACKER_RANGE_CHECK_EN to enable immediate range/alignment and format error reporting.
package instr_fmt_pkg;
  localparam logic [2:0] FMT_I_LOAD = 3'd0;
  localparam logic [2:0] FMT_I_ALU  = 3'd1;
  localparam logic [2:0] FMT_S      = 3'd2;
  localparam logic [2:0] FMT_S_CUST = 3'd3;
  localparam logic [2:0] FMT_B      = 3'd4;
  localparam logic [6:0] OP_I_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_I_ALU   = 7'b0010011;
  localparam logic [6:0] OP_S       = 7'b0100011;
  localparam logic [6:0] OP_S_CUST  = 7'b0001011;
  localparam logic [6:0] OP_B       = 7'b1100011;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
`ifdef PACKER_RANGE_CHECK_EN
  localparam bit RANGE_CHECK_EN = 1'b1;
`else
  localparam bit RANGE_CHECK_EN = 1'b0;
`endif
endpackage

// File: rtl/imm_scatter.sv
// imm_scatter: packs decoded fields into an RV32 word and flags immediate/format errors.
module imm_scatter
  import instr_fmt_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);
  logic i_ok, b_ok;
  assign i_ok = &imm[31:11] | ~|imm[31:11];
  assign b_ok = (&imm[31:12] | ~|imm[31:12]) & ~imm[0];
  always_comb begin
    instr = NOP_INSTR;
    err   = RANGE_CHECK_EN;
    case (fmt)
      FMT_I_LOAD, FMT_I_ALU: begin
        instr = {imm[11:0], rs1, funct3, rd, fmt == FMT_I_LOAD ? OP_I_LOAD : OP_I_ALU};
        err   = RANGE_CHECK_EN & ~i_ok;
      end
      FMT_S, FMT_S_CUST: begin
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], fmt == FMT_S ? OP_S : OP_S_CUST};
        err   = RANGE_CHECK_EN & ~i_ok;
      end
      FMT_B: begin
        instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_B};
        err   = RANGE_CHECK_EN & ~b_ok;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/instr_imm_packer.sv
// instr_imm_packer: handshaked instruction assembler with byte-address counter and error count.
// Error reporting is active only when PACKER_RANGE_CHECK_EN is defined.
module instr_imm_packer
  import instr_fmt_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [31:0]       in_imm,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [ERR_W-1:0]  err_cnt
);
  logic [31:0]       instr;
  logic              err, acc;
  logic [ADDR_W-1:0] cnt;
  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;
  imm_scatter u_scatter (
    .fmt(in_fmt), .rd(in_rd), .rs1(in_rs1), .rs2(in_rs2), .funct3(in_funct3),
    .imm(in_imm), .instr(instr), .err(err)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= '0;
      out_err   <= 1'b0;
      err_cnt   <= '0;
      cnt       <= '0;
    end else begin
      if (acc) begin
        out_valid <= 1'b1;
        out_instr <= instr;
        out_addr  <= cnt;
        out_err   <= err;
        if (err && !(&err_cnt)) err_cnt <= err_cnt + ERR_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // a load wins over the increment of a coincident accept
      cnt <= load_en ? (load_addr & ~ADDR_W'(3)) : acc ? cnt + ADDR_W'(4) : cnt;
    end
  end
endmodule
